// File: rtl/control_sequencer_if.sv
// Control/status bundle between the hardwired sequencer and the 32-bit
// bus datapath: instruction/handshake inputs plus every strobe it drives.
interface control_sequencer_if;
  // Inputs to the sequencer
  logic        run;
  logic [31:0] ir;
  logic        con_ff;
  logic        mem_ack;
  // Bus-source strobes
  logic pc_out, mdr_out, zlo_out, zhi_out, hi_out, lo_out, inport_out, c_out;
  // Register load strobes
  logic pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, con_in, outport_in;
  // ALU, memory and register-select controls
  logic       inc_pc;
  logic       read, write;
  logic       gra, grb, grc, r_in, r_out, ba_out;
  logic [4:0] alu_op;
  // Status
  logic       halted;
  logic       fault;

  // The sequencer side
  modport master (
    input  run, ir, con_ff, mem_ack,
    output pc_out, mdr_out, zlo_out, zhi_out, hi_out, lo_out, inport_out, c_out,
    output pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, con_in, outport_in,
    output inc_pc, read, write, gra, grb, grc, r_in, r_out, ba_out, alu_op,
    output halted, fault
  );

  // The datapath side
  modport slave (
    output run, ir, con_ff, mem_ack,
    input  pc_out, mdr_out, zlo_out, zhi_out, hi_out, lo_out, inport_out, c_out,
    input  pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, con_in, outport_in,
    input  inc_pc, read, write, gra, grb, grc, r_in, r_out, ba_out, alu_op,
    input  halted, fault
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the bus datapath.
// One T-state per clock; memory T-states stretch until mem_ack or time out.
module control_sequencer #(
  parameter int         WAIT_LIMIT = 16,
  parameter logic [4:0] OP_ADD     = 5'b00011
) (
  input logic              clk,
  input logic              clr,
  control_sequencer_if.master bus
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_LIMIT - 1);

  localparam logic [4:0] OPC_LD   = 5'b00000;
  localparam logic [4:0] OPC_LDI  = 5'b00001;
  localparam logic [4:0] OPC_ST   = 5'b00010;
  localparam logic [4:0] OPC_ADDI = 5'b01100;
  localparam logic [4:0] OPC_ANDI = 5'b01101;
  localparam logic [4:0] OPC_ORI  = 5'b01110;
  localparam logic [4:0] OPC_MUL  = 5'b01111;
  localparam logic [4:0] OPC_DIV  = 5'b10000;
  localparam logic [4:0] OPC_NEG  = 5'b10001;
  localparam logic [4:0] OPC_NOT  = 5'b10010;
  localparam logic [4:0] OPC_BR   = 5'b10011;
  localparam logic [4:0] OPC_IN   = 5'b10110;
  localparam logic [4:0] OPC_OUT  = 5'b10111;
  localparam logic [4:0] OPC_MFHI = 5'b11000;
  localparam logic [4:0] OPC_MFLO = 5'b11001;
  localparam logic [4:0] OPC_NOP  = 5'b11010;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    opcode_q;
  logic          fault_q, fault_d;
  logic [CW-1:0] wait_q, wait_d;

  logic          in_wait;
  state_t        ack_state;
  logic [4:0]    op;
  logic          is_r, is_imm, is_addr, is_md, is_nn, is_br;
  logic          unused_ir;

  // The IR register is loaded at the end of T2, so during T3 the opcode is
  // taken straight from ir; from T4 on the copy captured in T3 is used.
  assign op        = (state_q == S_T3) ? bus.ir[31:27] : opcode_q;
  assign unused_ir = ^bus.ir[26:0];

  assign is_r    = (op >= 5'b00011) && (op <= 5'b01011);
  assign is_imm  = (op == OPC_ADDI) || (op == OPC_ANDI) || (op == OPC_ORI);
  assign is_addr = (op == OPC_LD) || (op == OPC_LDI) || (op == OPC_ST);
  assign is_md   = (op == OPC_MUL) || (op == OPC_DIV);
  assign is_nn   = (op == OPC_NEG) || (op == OPC_NOT);
  assign is_br   = (op == OPC_BR);

  // State, sticky fault, wait counter and opcode capture
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= S_RESET;
      fault_q  <= 1'b0;
      wait_q   <= '0;
      opcode_q <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      wait_q  <= wait_d;
      if (state_q == S_T3) opcode_q <= bus.ir[31:27];
    end
  end

  // Next state and Moore strobes for the current T-state
  always_comb begin
    state_d        = state_q;
    fault_d        = fault_q;
    wait_d         = '0;
    in_wait        = 1'b0;
    ack_state      = S_T0;
    bus.pc_out     = 1'b0;
    bus.mdr_out    = 1'b0;
    bus.zlo_out    = 1'b0;
    bus.zhi_out    = 1'b0;
    bus.hi_out     = 1'b0;
    bus.lo_out     = 1'b0;
    bus.inport_out = 1'b0;
    bus.c_out      = 1'b0;
    bus.pc_in      = 1'b0;
    bus.ir_in      = 1'b0;
    bus.mar_in     = 1'b0;
    bus.mdr_in     = 1'b0;
    bus.y_in       = 1'b0;
    bus.z_in       = 1'b0;
    bus.hi_in      = 1'b0;
    bus.lo_in      = 1'b0;
    bus.con_in     = 1'b0;
    bus.outport_in = 1'b0;
    bus.inc_pc     = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.gra        = 1'b0;
    bus.grb        = 1'b0;
    bus.grc        = 1'b0;
    bus.r_in       = 1'b0;
    bus.r_out      = 1'b0;
    bus.ba_out     = 1'b0;
    bus.alu_op     = 5'b00000;
    bus.halted     = 1'b0;
    bus.fault      = fault_q;

    case (state_q)
      S_RESET: state_d = S_T0;

      S_T0: begin
        if (bus.run) begin
          bus.pc_out = 1'b1; bus.mar_in = 1'b1; bus.inc_pc = 1'b1; bus.z_in = 1'b1;
          state_d = S_T1;
        end
      end

      S_T1: begin
        bus.zlo_out = 1'b1; bus.pc_in = 1'b1; bus.read = 1'b1; bus.mdr_in = 1'b1;
        in_wait = 1'b1; ack_state = S_T2;
      end

      S_T2: begin
        bus.mdr_out = 1'b1; bus.ir_in = 1'b1;
        state_d = S_T3;
      end

      S_T3: begin
        state_d = S_T4;
        if (is_r || is_imm) begin
          bus.grb = 1'b1; bus.r_out = 1'b1; bus.y_in = 1'b1;
        end else if (is_addr) begin
          bus.grb = 1'b1; bus.ba_out = 1'b1; bus.y_in = 1'b1;
        end else if (is_md) begin
          bus.gra = 1'b1; bus.r_out = 1'b1; bus.y_in = 1'b1;
        end else if (is_nn) begin
          bus.grb = 1'b1; bus.r_out = 1'b1; bus.z_in = 1'b1; bus.alu_op = op;
        end else if (is_br) begin
          bus.gra = 1'b1; bus.r_out = 1'b1; bus.con_in = 1'b1;
        end else begin
          state_d = S_T0;
          case (op)
            OPC_IN:   begin bus.inport_out = 1'b1; bus.gra = 1'b1; bus.r_in = 1'b1; end
            OPC_OUT:  begin bus.gra = 1'b1; bus.r_out = 1'b1; bus.outport_in = 1'b1; end
            OPC_MFHI: begin bus.hi_out = 1'b1; bus.gra = 1'b1; bus.r_in = 1'b1; end
            OPC_MFLO: begin bus.lo_out = 1'b1; bus.gra = 1'b1; bus.r_in = 1'b1; end
            OPC_NOP:  state_d = S_T0;
            OPC_HALT: state_d = S_HALT;
            default: begin
              state_d = S_HALT;
              fault_d = 1'b1;
            end
          endcase
        end
      end

      S_T4: begin
        state_d = S_T5;
        if (is_r) begin
          bus.grc = 1'b1; bus.r_out = 1'b1; bus.z_in = 1'b1; bus.alu_op = op;
        end else if (is_imm) begin
          bus.c_out = 1'b1; bus.z_in = 1'b1;
          bus.alu_op = (op == OPC_ADDI) ? 5'b00011 : (op == OPC_ANDI) ? 5'b01010 : 5'b01011;
        end else if (is_addr) begin
          bus.c_out = 1'b1; bus.z_in = 1'b1; bus.alu_op = OP_ADD;
        end else if (is_md) begin
          bus.grb = 1'b1; bus.r_out = 1'b1; bus.z_in = 1'b1; bus.alu_op = op;
        end else if (is_nn) begin
          bus.zlo_out = 1'b1; bus.gra = 1'b1; bus.r_in = 1'b1;
          state_d = S_T0;
        end else begin
          bus.pc_out = 1'b1; bus.y_in = 1'b1;
        end
      end

      S_T5: begin
        if (op == OPC_LD || op == OPC_ST) begin
          bus.zlo_out = 1'b1; bus.mar_in = 1'b1;
          state_d = S_T6;
        end else if (is_md) begin
          bus.zlo_out = 1'b1; bus.lo_in = 1'b1;
          state_d = S_T6;
        end else if (is_br) begin
          bus.c_out = 1'b1; bus.z_in = 1'b1; bus.alu_op = OP_ADD;
          state_d = S_T6;
        end else begin
          bus.zlo_out = 1'b1; bus.gra = 1'b1; bus.r_in = 1'b1;
          state_d = S_T0;
        end
      end

      S_T6: begin
        if (op == OPC_LD) begin
          bus.read = 1'b1; bus.mdr_in = 1'b1;
          in_wait = 1'b1; ack_state = S_T7;
        end else if (op == OPC_ST) begin
          bus.gra = 1'b1; bus.r_out = 1'b1; bus.mdr_in = 1'b1;
          state_d = S_T7;
        end else if (is_md) begin
          bus.zhi_out = 1'b1; bus.hi_in = 1'b1;
          state_d = S_T0;
        end else begin
          // Branch commit: the target is written to PC only when taken.
          bus.zlo_out = 1'b1; bus.pc_in = bus.con_ff;
          state_d = S_T0;
        end
      end

      S_T7: begin
        if (op == OPC_ST) begin
          bus.write = 1'b1;
          in_wait = 1'b1; ack_state = S_T0;
        end else begin
          bus.mdr_out = 1'b1; bus.gra = 1'b1; bus.r_in = 1'b1;
          state_d = S_T0;
        end
      end

      S_HALT: bus.halted = 1'b1;

      default: state_d = S_T0;
    endcase

    // Memory handshake: an ack on the last permitted cycle still succeeds.
    if (in_wait) begin
      if (bus.mem_ack) begin
        state_d = ack_state;
      end else if (wait_q == WAIT_LAST) begin
        state_d = S_HALT;
        fault_d = 1'b1;
      end else begin
        state_d = state_q;
        wait_d  = wait_q + CW'(1);
      end
    end
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that sequences the 32-bit bus-based datapath.
- The datapath comprises R0–R15, PC, IR, HI, LO, MAR/MDR, Y/Z and the ALU.
- Runs a fetch/decode/execute FSM and drives one-hot bus-out/register-in strobes, ALU op, memory read/write and register-select fields for each T-state.
- Waits on a memory acknowledge with timeout; halts on halt opcode, illegal opcode or memory fault.

Parameters:
- WAIT_LIMIT, 16: maximum cycles a read/write may wait for mem_ack before fault.
- OP_ADD, 5'b00011: alu_op code driven for address and branch-target additions.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous active-high reset.
- run  in  1  1 = fetching permitted. Sampled only in T0.
- ir  in  32  IR contents. Opcode is ir[31:27].
- con_ff  in  1  branch-condition flag, valid in T6 of br.
- mem_ack  in  1  memory completes the current read/write this cycle.
- pc_out, mdr_out, zlo_out, zhi_out, hi_out, lo_out, inport_out, c_out  out  1 each  bus-source strobes (at most one high per cycle).
- pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, con_in, outport_in  out  1 each  register load strobes.
- inc_pc  out  1  ALU computes PC+1.
- read, write  out  1 each  memory request, held until mem_ack.
- gra, grb, grc, r_in, r_out, ba_out  out  1 each  register-select decode controls.
- alu_op  out  5  ALU operation.
- halted  out  1  FSM in HALT.
- fault  out  1  HALT entered due to timeout or illegal opcode (sticky until clr).

Behaviour:
- Outputs are Moore, decoded from state and the opcode latched at T2+1. Default for every output is 0.
- clr=1 at a clock edge forces state RESET and clears halted, fault and the wait counter, including mid-instruction and mid-handshake. RESET lasts 1 cycle, then T0.
- T0: if run=0, stay in T0 with all outputs 0. If run=1, assert pc_out, mar_in, inc_pc, z_in; next state T1.
- T1: zlo_out, pc_in, read, mdr_in. Hold T1 until mem_ack=1, then go to T2.
- T2: mdr_out, ir_in. Next cycle the opcode is latched from ir; go to T3.
- Execute sequences by opcode. After the last step, go to T0.
  - R-type ALU (00011–01011, alu_op=opcode): T3 grb r_out y_in; T4 grc r_out z_in; T5 zlo_out gra r_in.
  - Immediate ALU (01100 addi, 01101 andi, 01110 ori; alu_op = 00011/01010/01011 respectively): T3 grb r_out y_in; T4 c_out z_in; T5 zlo_out gra r_in.
  - ldi (00001): T3 grb ba_out y_in; T4 c_out alu_op=OP_ADD z_in; T5 zlo_out gra r_in.
  - ld (00000): T3/T4 as ldi; T5 zlo_out mar_in; T6 read mdr_in, held to mem_ack; T7 mdr_out gra r_in.
  - st (00010): T3–T5 as ld; T6 gra r_out mdr_in; T7 write, held to mem_ack.
  - mul/div (01111/10000): T3 gra r_out y_in; T4 grb r_out z_in; T5 zlo_out lo_in; T6 zhi_out hi_in.
  - neg/not (10001/10010): T3 grb r_out z_in; T4 zlo_out gra r_in.
  - br (10011): T3 gra r_out con_in; T4 pc_out y_in; T5 c_out alu_op=OP_ADD z_in; T6 zlo_out with pc_in only if con_ff=1.
  - in (10110): T3 inport_out gra r_in.
  - out (10111): T3 gra r_out outport_in.
  - mfhi (11000): T3 hi_out gra r_in.
  - mflo (11001): T3 lo_out gra r_in.
  - nop (11010): return to T0 directly after T2+1.
  - halt (11011): enter HALT.
  - Any other opcode: enter HALT with fault=1.
- Wait counter:
  - Starts at 0 on entering any read/write wait state and increments each cycle without mem_ack.
  - Reaching WAIT_LIMIT without ack: deassert read/write, enter HALT, set fault=1.
  - mem_ack in the same cycle the counter hits WAIT_LIMIT counts as success.
- HALT: all strobes 0, halted=1; remains until clr. run and mem_ack are ignored.
- mem_ack outside a wait state is ignored.

Test Plan:
- clr=1 for 2 cycles, run=1, mem_ack tied 1 → T0 strobes (pc_out, mar_in, inc_pc, z_in) on cycle 2 after clr release; all outputs 0 during reset.
- IR=add (00011…), mem_ack=1 immediately → exact strobe sequence T0..T5 over 6 cycles, alu_op=00011 in T4, back to T0 on cycle 7.
- ld with mem_ack delayed 3 cycles in T1 and 2 cycles in T6 → read held 4 and 3 cycles respectively; mdr_out/gra/r_in in T7.
- br with con_ff=0, then with con_ff=1 → pc_in absent/present in T6; zlo_out present in both.
- mem_ack held 0 during fetch, WAIT_LIMIT=16 → read high 16 cycles, then halted=1, fault=1. Assert clr mid-wait in a second run → RESET then T0, fault=0.
- IR opcode 11111, then separately 11011 → HALT with fault=1 vs fault=0; run toggling in HALT has no effect.
